matrix_port_arbiter: RTL and testbench
======================================

# matrix_port_arbiter

Round-robin arbiter sharing the single write port of the game-matrix row memory (5-bit row address, 10-bit row data) among `NREQ` requesters: the token generator, the line-clear engine and the gravity/shift engine. A requester holds a grant for a burst of row writes. The arbiter registers the granted requester's write onto the memory bus and enforces a maximum hold time. It sits between the requesters and the matrix RAM, and is the only driver of the RAM write port.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (index 0 = token generator).
- `ROWS`, 20, valid row addresses are 0..ROWS-1.
- `MAX_HOLD`, 16, maximum cycles a grant is held.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in NREQ: request / hold-ownership, one bit per requester.
- `we` in NREQ: write strobe; honoured only for the current owner.
- `addr` in NREQ*5: packed row addresses; requester i at bits [5i+4:5i].
- `data` in NREQ*10: packed row data; requester i at bits [10i+9:10i].
- `gnt` out NREQ: one-hot grant, registered.
- `mem_addr` out 5: registered RAM address.
- `mem_data` out 10: registered RAM data.
- `mem_we` out 1: registered RAM write enable.
- `busy` out 1: high when state is not IDLE.
- `timeout_err` out 1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.
- `range_err` out 1: one-cycle pulse when the owner writes with addr ≥ ROWS.

## Operation
- FSM states: IDLE, GRANT, RELEASE. Encoded as a 2-bit enum.
- **IDLE**
  - If any `req` bit is high → GRANT. The owner is the first requesting index found searching from `last+1` upward, wrapping modulo NREQ.
  - `gnt[owner]` is set and `hold_cnt` is cleared to 0.
- **GRANT**
  - Each cycle, if `req[owner]` and `we[owner]` are both high and `addr` < ROWS: on the next edge `mem_we`=1, and `mem_addr`/`mem_data` take the owner's values.
  - If the owner writes with `addr` ≥ ROWS: `mem_we`=0 and `range_err` pulses.
  - Inputs from non-owners are ignored.
  - `hold_cnt` increments every GRANT cycle.
  - `req[owner]` low → RELEASE. A `we` asserted in that same cycle is ignored.
  - `hold_cnt` == MAX_HOLD-1 with `req[owner]` still high → RELEASE, and `timeout_err`=1 during the RELEASE cycle. The write in that last cycle is still performed.
- **RELEASE**
  - `gnt`=0, `mem_we`=0, `last`←owner.
  - Unconditionally → IDLE.
- A timed-out requester that keeps `req` high is treated as a fresh request at the lowest round-robin priority.
- `mem_addr`/`mem_data` hold their last values when `mem_we`=0.
- `hold_cnt` width is clog2(MAX_HOLD+1).

## Timing
- Reset values: state IDLE, `gnt`=0, `mem_addr`=0, `mem_data`=0, `mem_we`=0, `busy`=0, `timeout_err`=0, `range_err`=0, `last`=NREQ-1 (requester 0 has top priority first).
- Reset asserted mid-burst clears all of the above immediately, including any in-flight `mem_we`.
- Latency:
  - `req` high at edge k → `gnt` high after edge k+1.
  - Owner write presented in cycle j → `mem_we` high in cycle j+1.
- Back-to-back grants: minimum 3 cycles from release to the next grant (RELEASE, then IDLE, then GRANT).
- Maximum grant duration: MAX_HOLD cycles.
- Simultaneous requests from all requesters are served in rotation 0,1,2,0,…
- `req` dropping in the same cycle as a timeout → normal release, with no `timeout_err`.

## Structure
- Shared package `matrix_pkg` holds:
  - `ROW_W`=10, `ADDR_W`=5, `ROWS`=20.
  - The `arb_state_t` enum {IDLE, GRANT, RELEASE}.
  - The token-ID typedef used by the token generator.
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `pick` and `any`.
  - Reusable by a future read-port arbiter.

## Test plan
- **Reset, then single request:** reset, then `req`=3'b001 with a 3-write burst to rows 0,1,2 of data 0x000, 0x020, 0x030 → `gnt`=001 one cycle later; `mem_we` pulses on 3 consecutive cycles, each one cycle behind its write, with matching addr/data; `gnt`=0 after `req` drops.
- **Round-robin:** `req`=3'b111 held, each owner drops `req` after 2 writes and re-raises it → grant order 0,1,2,0; no `mem_we` from non-owners.
- **Timeout:** requester 1 holds `req` and `we` for 20 cycles → exactly 16 writes; `timeout_err` pulses once; grant then goes to pending requester 2 before returning to 1.
- **Range error:** owner writes addr 25 → `mem_we` stays 0 and `range_err` pulses once; a following write to row 19 succeeds.
- **Reset mid-burst:** assert `reset` while `mem_we`=1 → all outputs 0 immediately; after release, requester 0 wins over a simultaneous requester 2.
- **Coincident release and timeout:** owner drops `req` in cycle 15 of its hold → normal release with no `timeout_err`.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the game-matrix row memory and its
// requesters.
//   ROW_W / ADDR_W / ROWS : row data width, row address width, row count.
//   arb_state_t           : write-port arbiter state.
//   token_id_t            : piece identifier produced by the token generator.
//   row_in_range()        : true when a row address addresses a real row.
package matrix_pkg;

  localparam int ROW_W  = 10;
  localparam int ADDR_W = 5;
  localparam int ROWS   = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef logic [2:0] token_id_t;

  function automatic logic row_in_range(input logic [ADDR_W-1:0] a, input int rows);
    return int'(a) < rows;
  endfunction

endpackage

// File: rtl/matrix_port_arbiter_if.sv
// matrix_port_arbiter_if: bundle between the requesters, the write-port
// arbiter and the matrix RAM write port.
//   req/we/addr/data : per-requester request, write strobe, packed row
//                      address (5 bits each) and row data (10 bits each).
//   gnt              : one-hot grant back to the requesters.
//   mem_*            : registered RAM write port.
//   busy/timeout_err/range_err : arbiter status.
// Modports: master = requester/RAM side, slave = arbiter.
interface matrix_port_arbiter_if #(
  parameter int NREQ = 3
) ();
  import matrix_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*ROW_W-1:0]  data;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      mem_addr;
  logic [ROW_W-1:0]       mem_data;
  logic                   mem_we;
  logic                   busy;
  logic                   timeout_err;
  logic                   range_err;

  modport master (
    output req, we, addr, data,
    input  gnt, mem_addr, mem_data, mem_we, busy, timeout_err, range_err
  );

  modport slave (
    input  req, we, addr, data,
    output gnt, mem_addr, mem_data, mem_we, busy, timeout_err, range_err
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  : request vector, one bit per requester.
//   last : index of the most recently served requester.
//   pick : one-hot winner, first requesting index searched from last+1
//          upward, wrapping modulo NREQ (last itself has lowest priority).
//   any  : at least one request is present.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  logic found;
  int   idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + int'(k)) % NREQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/matrix_port_arbiter.sv
// matrix_port_arbiter: round-robin owner of the matrix RAM write port.
//   clk, reset : rising-edge clock, asynchronous active-high reset.
//   bus        : slave modport; requester req/we/addr/data in, one-hot gnt,
//                registered mem_addr/mem_data/mem_we, busy, and one-cycle
//                timeout_err / range_err pulses out.
// A grant lasts at most MAX_HOLD cycles; each grant is followed by one
// RELEASE and one IDLE cycle before the next owner is chosen.
module matrix_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int ROWS     = 20,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_port_arbiter_if.slave bus
);
  import matrix_pkg::*;

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t        state_q, state_d;
  logic [LW-1:0]     owner_q, owner_d;
  logic [LW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [HW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [ROW_W-1:0]  mdata_q, mdata_d;
  logic              mwe_q, mwe_d;
  logic              tmo_q, tmo_d;
  logic              rng_q, rng_d;

  logic [NREQ-1:0]   pick;
  logic              any_req;
  logic [LW-1:0]     pick_idx;

  logic              own_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [ROW_W-1:0]  own_data;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req  (bus.req),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick[k]) pick_idx = LW'(k);
    end
  end

  assign own_req  = bus.req[owner_q];
  assign own_we   = bus.we[owner_q];
  assign own_addr = bus.addr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign own_data = bus.data[int'(owner_q)*ROW_W +: ROW_W];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mwe_d   = 1'b0;
    tmo_d   = 1'b0;
    rng_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (!own_req) begin
          // a strobe alongside a dropped request is not a write
          state_d = RELEASE;
          gnt_d   = '0;
        end else begin
          if (own_we) begin
            if (row_in_range(own_addr, ROWS)) begin
              mwe_d   = 1'b1;
              maddr_d = own_addr;
              mdata_d = own_data;
            end else begin
              rng_d = 1'b1;
            end
          end
          // the final write of a timed-out grant still lands
          if (cnt_q == HW'(MAX_HOLD - 1)) begin
            state_d = RELEASE;
            gnt_d   = '0;
            tmo_d   = 1'b1;
          end
        end
      end
      RELEASE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LW'(NREQ - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      mwe_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mwe_q   <= mwe_d;
      tmo_q   <= tmo_d;
      rng_q   <= rng_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.mem_addr    = maddr_q;
  assign bus.mem_data    = mdata_q;
  assign bus.mem_we      = mwe_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = tmo_q;
  assign bus.range_err   = rng_q;

endmodule

// File: tb/tb_matrix_port_arbiter.sv
// tb_matrix_port_arbiter: directed scenarios for the matrix write-port
// arbiter, checked every cycle against a behavioural ownership model, plus
// hand-computed literal expectations at key points of each scenario.
module tb_matrix_port_arbiter;

  localparam int N    = 3;
  localparam int NROW = 20;
  localparam int HOLD = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  matrix_port_arbiter_if #(.NREQ(N)) bus ();

  matrix_port_arbiter #(
    .NREQ     (N),
    .ROWS     (NROW),
    .MAX_HOLD (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the port, how long it has held it, and
  // whether we are in the one-cycle cool-down that follows every grant.
  int m_owner = -1;
  bit m_cool  = 1'b0;
  int m_last  = N - 1;
  int m_held  = 0;
  int cand    = 0;
  int a_in    = 0;
  bit e_we    = 1'b0;
  bit e_tmo   = 1'b0;
  bit e_rng   = 1'b0;
  int e_addr  = 0;
  int e_data  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_cool = 1'b0; m_last = N - 1; m_held = 0;
      e_we = 1'b0; e_tmo = 1'b0; e_rng = 1'b0; e_addr = 0; e_data = 0;
    end else begin
      e_we = 1'b0; e_tmo = 1'b0; e_rng = 1'b0;
      if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          cand = (m_last + k) % N;
          if (m_owner < 0 && bus.req[cand]) begin
            m_owner = cand;
            m_held  = 0;
          end
        end
      end else if (!bus.req[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_cool = 1'b1;
      end else begin
        if (bus.we[m_owner]) begin
          a_in = int'(bus.addr[m_owner*5 +: 5]);
          if (a_in < NROW) begin
            e_we = 1'b1; e_addr = a_in; e_data = int'(bus.data[m_owner*10 +: 10]);
          end else begin
            e_rng = 1'b1;
          end
        end
        m_held++;
        if (m_held == HOLD) begin
          e_tmo = 1'b1; m_last = m_owner; m_owner = -1; m_cool = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt",         int'(bus.gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      check("busy",        int'(bus.busy), int'((m_owner >= 0) || m_cool));
      check("mem_we",      int'(bus.mem_we), int'(e_we));
      check("mem_addr",    int'(bus.mem_addr), e_addr);
      check("mem_data",    int'(bus.mem_data), e_data);
      check("timeout_err", int'(bus.timeout_err), int'(e_tmo));
      check("range_err",   int'(bus.range_err), int'(e_rng));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_wr(input int i, input bit w, input int a, input int d);
    bus.we[i]            = w;
    bus.addr[i*5 +: 5]   = 5'(a);
    bus.data[i*10 +: 10] = 10'(d);
  endtask

  task automatic wait_gnt(input int i, input int budget);
    int n = 0;
    while (bus.gnt[i] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_gnt", int'(bus.gnt[i]), 1);
  endtask

  int order[$];
  int exp_order[4] = '{0, 1, 2, 0};
  int writes;
  int tmos;
  int own;
  int n_wait;

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.data = '0;
    tick();
    // reset state while reset is still asserted
    check("rst_gnt",    int'(bus.gnt), 0);
    check("rst_busy",   int'(bus.busy), 0);
    check("rst_mem_we", int'(bus.mem_we), 0);
    check("rst_addr",   int'(bus.mem_addr), 0);
    check("rst_data",   int'(bus.mem_data), 0);
    check("rst_errs",   int'({bus.timeout_err, bus.range_err}), 0);
    tick();
    reset  = 1'b0;
    cmp_en = 1'b1;

    // single request, 3-write burst
    bus.req[0] = 1'b1;
    tick();
    check("s1_gnt", int'(bus.gnt), 3'b001);
    set_wr(0, 1'b1, 0, 'h000); tick();
    check("s1_w0", int'({bus.mem_we, bus.mem_addr, bus.mem_data}), {1'b1, 5'd0, 10'h000});
    set_wr(0, 1'b1, 1, 'h020); tick();
    check("s1_w1", int'({bus.mem_we, bus.mem_addr, bus.mem_data}), {1'b1, 5'd1, 10'h020});
    set_wr(0, 1'b1, 2, 'h030); tick();
    check("s1_w2", int'({bus.mem_we, bus.mem_addr, bus.mem_data}), {1'b1, 5'd2, 10'h030});
    bus.req[0] = 1'b0; set_wr(0, 1'b0, 0, 0); tick();
    check("s1_rel", int'({bus.gnt, bus.mem_we, bus.busy, bus.mem_addr}), {3'b000, 1'b0, 1'b1, 5'd2});
    tick();
    check("s1_idle", int'(bus.busy), 0);

    // round-robin under continuous contention
    do_reset();
    for (int i = 0; i < N; i++) set_wr(i, 1'b1, i + 4, 'h100 + i);
    bus.req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      n_wait = 0;
      while (bus.gnt === 3'b000 && n_wait < 8) begin tick(); n_wait++; end
      check("rr_wait", int'(bus.gnt != 3'b000), 1);
      own = 0;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) own = i;
      order.push_back(own);
      tick(); tick();
      bus.req[own] = 1'b0;
      tick();
      bus.req[own] = 1'b1;
    end
    check("rr_count", order.size(), 4);
    for (int r = 0; r < 4 && r < order.size(); r++) check("rr_order", order[r], exp_order[r]);
    bus.req = '0; bus.we = '0;
    repeat (4) tick();

    // timeout with requester 2 waiting
    do_reset();
    bus.req[1] = 1'b1; set_wr(1, 1'b1, 5, 'h155);
    wait_gnt(1, 5);
    bus.req[2] = 1'b1;
    writes = 0; tmos = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.mem_we) writes++;
      if (bus.timeout_err) tmos++;
      if (t == 16) check("to_pulse", int'({bus.gnt, bus.timeout_err}), {3'b000, 1'b1});
      if (t == 18) check("to_next_gnt", int'(bus.gnt), 3'b100);
    end
    check("to_writes", writes, 16);
    check("to_pulses", tmos, 1);
    bus.req[2] = 1'b0;
    wait_gnt(1, 6);
    bus.req[1] = 1'b0; set_wr(1, 1'b0, 0, 0);
    repeat (3) tick();

    // out-of-range row, then last valid row
    do_reset();
    bus.req[0] = 1'b1;
    wait_gnt(0, 4);
    set_wr(0, 1'b1, 25, 'h3ff); tick();
    check("rg_err", int'({bus.mem_we, bus.range_err, bus.mem_addr}), {1'b0, 1'b1, 5'd0});
    set_wr(0, 1'b1, 19, 'h2aa); tick();
    check("rg_ok", int'({bus.mem_we, bus.range_err, bus.mem_addr, bus.mem_data}),
          {1'b1, 1'b0, 5'd19, 10'h2aa});
    bus.req[0] = 1'b0; set_wr(0, 1'b0, 0, 0);
    repeat (3) tick();

    // reset during a write burst
    bus.req[0] = 1'b1; set_wr(0, 1'b1, 3, 'h0f0);
    wait_gnt(0, 4);
    tick();
    check("mr_pre_we", int'(bus.mem_we), 1);
    #1 reset = 1'b1;
    #1;
    check("mr_outs", int'({bus.gnt, bus.mem_we, bus.busy, bus.mem_addr, bus.mem_data}), 0);
    set_wr(0, 1'b0, 0, 0);
    bus.req = 3'b101;
    tick();
    reset = 1'b0;
    tick();
    check("mr_winner", int'(bus.gnt), 3'b001);
    bus.req = '0;
    repeat (3) tick();

    // release coinciding with the last allowed hold cycle
    do_reset();
    bus.req[0] = 1'b1; set_wr(0, 1'b1, 7, 'h007);
    wait_gnt(0, 4);
    writes = 0;
    repeat (15) begin
      tick();
      if (bus.mem_we) writes++;
    end
    bus.req[0] = 1'b0; set_wr(0, 1'b0, 0, 0);
    tick();
    check("co_rel", int'({bus.gnt, bus.timeout_err, bus.mem_we, bus.busy}), {3'b000, 1'b0, 1'b0, 1'b1});
    check("co_writes", writes, 15);
    tick();
    check("co_idle", int'(bus.busy), 0);
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

endmodule
